// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSN             = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP              = 32'd4;

    // One fetched instruction as handed to decode.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        exc;
    } fetch_entry_t;

    // Value presented on the head port whenever the queue is empty.
    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0000_0000, insn: NOP_INSN, exc: 1'b0};

endpackage

// File: rtl/fetch_queue.sv
// QDEPTH-entry circular FIFO of fetch_entry_t. Flush wins over push and pop.
// An empty queue presents EMPTY_ENTRY on head_o.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned  QDEPTH = 2,
    localparam int unsigned PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1)
)(
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             push_i,
    input  fetch_entry_t     push_entry_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o,
    output fetch_entry_t     head_o
);

    fetch_entry_t     mem_q [QDEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push = push_i && !flush_i;
    assign do_pop  = pop_i && !flush_i && !empty_o;

    // Pointer and occupancy next-state.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through a non-empty head.
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign full_o  = (count_q == CNT_W'(QDEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = empty_o ? EMPTY_ENTRY : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency memory reads,
// queues {pc, insn, exc} for decode and handles redirects.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetched/stall counter ports.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int unsigned QDEPTH       = 2
)(
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_imem_pc,
    input  logic [31:0] i_imem_insn,
    input  logic        i_imem_exception,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_pc,
    output logic [31:0] o_insn,
    output logic        o_exc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] o_perf_fetched,
    output logic [31:0] o_perf_stall
`endif
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             req_exc_q, req_exc_d;
    logic             inflight_q, inflight_d;
    logic             halt_q, halt_d;

    logic             q_push;
    logic             q_pop;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;
    logic [OCC_W-1:0] occupancy;
    logic             issue;

    // Slots committed after this cycle: queued + returning word - departing head.
    assign q_pop     = !q_empty && i_ready;
    assign occupancy = OCC_W'(q_count) + OCC_W'(inflight_q) - OCC_W'(q_pop);
    assign issue     = !i_redirect_valid && !halt_q && (occupancy < OCC_W'(QDEPTH));

    // The word for last cycle's request lands now; a faulting fetch carries a NOP.
    assign q_push     = inflight_q;
    assign push_entry = '{pc:   req_pc_q,
                          insn: req_exc_q ? NOP_INSN : i_imem_insn,
                          exc:  req_exc_q};

    // PC, request tracking and halt next-state; redirect overrides everything.
    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        req_exc_d  = req_exc_q;
        inflight_d = 1'b0;
        halt_d     = halt_q;
        if (i_redirect_valid) begin
            pc_d   = i_redirect_pc;
            halt_d = 1'b0;
        end else if (issue) begin
            inflight_d = 1'b1;
            req_pc_d   = pc_q;
            req_exc_d  = i_imem_exception;
            pc_d       = pc_q + PC_STEP;
            // Halting at issue keeps a second request from slipping out before
            // the faulting entry is queued.
            if (i_imem_exception) halt_d = 1'b1;
        end
    end

    // Fetch state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q       <= RESET_VECTOR;
            req_pc_q   <= 32'h0000_0000;
            req_exc_q  <= 1'b0;
            inflight_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            req_exc_q  <= req_exc_d;
            inflight_q <= inflight_d;
            halt_q     <= halt_d;
        end
    end

    fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .push_i       (q_push),
        .push_entry_i (push_entry),
        .pop_i        (q_pop),
        .flush_i      (i_redirect_valid),
        .full_o       (q_full),
        .empty_o      (q_empty),
        .count_o      (q_count),
        .head_o       (head_entry)
    );

    assign o_imem_pc = pc_q;
    assign o_valid   = !q_empty;
    assign o_pc      = head_entry.pc;
    assign o_insn    = head_entry.insn;
    assign o_exc     = head_entry.exc;

    // The issue rule must never let a returning word meet a full, non-draining queue.
    push_when_full_a: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !(q_push && q_full && !q_pop && !i_redirect_valid));

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Pop and stall counters; redirect cycles are not counted.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (!i_redirect_valid) begin
            if (q_pop)              perf_fetched_d = perf_fetched_q + 32'd1;
            if (o_valid && !i_ready) perf_stall_d  = perf_stall_q + 32'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            perf_fetched_q <= 32'h0;
            perf_stall_q   <= 32'h0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign o_perf_fetched = perf_fetched_q;
    assign o_perf_stall   = perf_stall_q;
`endif

endmodule
